// File: rtl/vec_magnitude_seq_if.sv
// Start/done handshake bundle for the sequential vector-magnitude unit.
// The master drives the operands and start; the slave returns busy/done/mag.
interface vec_magnitude_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   mag;

   modport master (
      output start, x, y,
      input  busy, done, mag
   );

   modport slave (
      input  start, x, y,
      output busy, done, mag
   );
endinterface

// File: rtl/vec_magnitude_seq.sv
// Multi-cycle mag = sqrt(x^2 + y^2): shift-add squares, restoring root.
// Define VEC_MAG_ROUND_EN for round-to-nearest instead of floor.
module vec_magnitude_seq #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   vec_magnitude_seq_if.slave  io_bus
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam int AW = 2 * WIDTH + 2;
   localparam int RW = WIDTH + 3;

   localparam logic [CW-1:0] SQ_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] RT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SQX,
      SQY,
      SQRT
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [CW-1:0]   r_cnt;
   logic            w_last;

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [AW-1:0]    r_acc;
   logic [RW-1:0]    r_rem;
   logic [WIDTH:0]   r_root;
   logic [WIDTH:0]   r_mag;
   logic             r_done;

   logic [WIDTH-1:0] w_op;
   logic [WIDTH-1:0] w_sel;
   logic             w_bit;
   logic [AW-1:0]    w_add;
   logic [1:0]       w_pair;
   logic [RW-1:0]    w_rem_sh;
   logic [RW-1:0]    w_trial;
   logic             w_ge;
   logic [RW-1:0]    w_rem_nx;
   logic [WIDTH:0]   w_root_nx;
   logic [WIDTH:0]   w_mag_nx;

   // ---------------- control ----------------
   assign w_last = (r_state == SQRT) ? (r_cnt == RT_LAST)
                                     : (r_cnt == SQ_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE: begin
            if (io_bus.start) w_state_nx = SQX;
         end
         SQX: begin
            if (w_last) w_state_nx = SQY;
         end
         SQY: begin
            if (w_last) w_state_nx = SQRT;
         end
         SQRT: begin
            if (w_last) w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Iteration index restarts at zero on every state entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == IDLE || w_state_nx != r_state) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // ---------------- squarer ----------------
   assign w_op  = (r_state == SQY) ? r_y : r_x;
   assign w_sel = {{(WIDTH-1){1'b0}}, 1'b1} << r_cnt;
   assign w_bit = |(w_op & w_sel);
   assign w_add = {{(WIDTH+2){1'b0}}, w_op} << r_cnt;

   // ---------------- root ----------------
   // acc is shifted left two bits per step so its top pair is the next digit
   assign w_pair    = r_acc[AW-1:AW-2];
   assign w_rem_sh  = (r_rem << 2) | {{(RW-2){1'b0}}, w_pair};
   assign w_trial   = {r_root, 2'b01};
   assign w_ge      = (w_rem_sh >= w_trial);
   assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
   assign w_root_nx = (r_root << 1) | {{WIDTH{1'b0}}, w_ge};

`ifdef VEC_MAG_ROUND_EN
   logic w_inc;
   // rem > root after the last step means S >= r^2 + r + 1
   assign w_inc    = (w_rem_nx > {2'b00, w_root_nx});
   assign w_mag_nx = w_root_nx + {{WIDTH{1'b0}}, w_inc};
`else
   assign w_mag_nx = w_root_nx;
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_acc  <= '0;
         r_rem  <= '0;
         r_root <= '0;
         r_mag  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (io_bus.start) begin
                  r_x    <= io_bus.x;
                  r_y    <= io_bus.y;
                  r_acc  <= '0;
                  r_rem  <= '0;
                  r_root <= '0;
               end
            end
            SQX, SQY: begin
               if (w_bit) r_acc <= r_acc + w_add;
            end
            SQRT: begin
               r_acc  <= r_acc << 2;
               r_rem  <= w_rem_nx;
               r_root <= w_root_nx;
               if (w_last) begin
                  r_mag  <= w_mag_nx;
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.busy = (r_state != IDLE);
   assign io_bus.done = r_done;
   assign io_bus.mag  = r_mag;

endmodule
